// File: rtl/core_dispatch_queue_if.sv
// Shared instruction types and the decode/dispatch-facing bundle of the
// dispatch queue.
//
// core_dispatch_queue_pkg : decoded-instruction record (insn_decode).
// core_dispatch_queue_if  : push side (in_valid_a/b, in_a/b, in_ready),
//                           slot side (cur_a/b, dispatch_a/b), flush, count.
//   modport master : driven by decode/dispatch (testbench or parent).
//   modport slave  : the queue itself.

package core_dispatch_queue_pkg;

  // Control bits carried with each decoded instruction.  execute = 0 marks a
  // bubble as seen by the dispatch hazard logic.
  typedef struct packed {
    logic       execute;
    logic [3:0] alu_op;
    logic [4:0] rd;
  } insn_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    insn_ctrl    ctrl;
  } insn_decode;

endpackage

interface core_dispatch_queue_if #(
  parameter int DEPTH = 8
);
  import core_dispatch_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid_a;
  logic          in_valid_b;
  insn_decode    in_a;
  insn_decode    in_b;
  logic          in_ready;
  logic          flush;
  logic          dispatch_a;
  logic          dispatch_b;
  insn_decode    cur_a;
  insn_decode    cur_b;
  logic [CW-1:0] count;

  modport master (
    output in_valid_a, in_valid_b, in_a, in_b, flush, dispatch_a, dispatch_b,
    input  in_ready, cur_a, cur_b, count
  );

  modport slave (
    input  in_valid_a, in_valid_b, in_a, in_b, flush, dispatch_a, dispatch_b,
    output in_ready, cur_a, cur_b, count
  );

endinterface

// File: rtl/core_dispatch_queue.sv
// Decoded-instruction queue in front of the dual-issue dispatch hazard logic.
// Accepts up to two instructions per cycle, keeps them in order in a circular
// buffer and presents the two oldest as slots A/B.  Dispatch verdicts retire
// zero, one or two entries per cycle; flush discards everything.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : core_dispatch_queue_if.slave
//            in_valid_a/b, in_a/b -> push of up to two instructions (b only with a)
//            in_ready             <- push accepted this cycle (free slots >= 2)
//            flush                -> drop all entries (highest priority)
//            dispatch_a/b         -> retire verdicts for the presented slots
//            cur_a/b              <- oldest / second-oldest entry, bubble if empty
//            count                <- registered number of valid entries

module core_dispatch_queue
  import core_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  core_dispatch_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] ZERO_C      = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TWO_C       = {{(CW-2){1'b0}}, 2'b10};
  localparam logic [CW-1:0] READY_MAX_C = CW'(DEPTH - 2);
  localparam logic [PW-1:0] PONE_C      = {{(PW-1){1'b0}}, 1'b1};

  // Registered state
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          in_ready_r;
  insn_decode    mem_r [DEPTH];

  // Next-state helpers
  logic          pop_a_s;
  logic          pop_b_s;
  logic [CW-1:0] pop_n_s;
  logic [CW-1:0] push_n_s;
  logic [CW-1:0] count_nxt_s;
  logic [PW-1:0] head_p1_s;
  logic [PW-1:0] tail_p1_s;
  insn_decode    cur_a_s;
  insn_decode    cur_b_s;

  assign head_p1_s = head_r + PONE_C;
  assign tail_p1_s = tail_r + PONE_C;

  // Retire decision: B can only go with A, and verdicts on bubble slots are ignored.
  always_comb begin
    pop_a_s = 1'b0;
    pop_b_s = 1'b0;
    pop_n_s = ZERO_C;
    if (bus.dispatch_a && (count_r != ZERO_C)) begin
      pop_a_s = 1'b1;
    end else begin
      pop_a_s = 1'b0;
    end
    if (pop_a_s && bus.dispatch_b && (count_r >= TWO_C)) begin
      pop_b_s = 1'b1;
    end else begin
      pop_b_s = 1'b0;
    end
    pop_n_s = {{(CW-1){1'b0}}, pop_a_s} + {{(CW-1){1'b0}}, pop_b_s};
  end

  // Push size: gated by the registered ready so dispatch never reaches decode
  // combinationally.
  always_comb begin
    push_n_s = ZERO_C;
    if (in_ready_r && bus.in_valid_a) begin
      if (bus.in_valid_b) begin
        push_n_s = TWO_C;
      end else begin
        push_n_s = ONE_C;
      end
    end else begin
      push_n_s = ZERO_C;
    end
  end

  assign count_nxt_s = count_r + push_n_s - pop_n_s;

  // Pointer, occupancy and ready registers; flush overrides same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= ZERO_C;
      in_ready_r <= 1'b1;
    end else if (bus.flush) begin
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= ZERO_C;
      in_ready_r <= 1'b1;
    end else begin
      head_r     <= head_r + pop_n_s[PW-1:0];
      tail_r     <= tail_r + push_n_s[PW-1:0];
      count_r    <= count_nxt_s;
      // Ready for the next cycle is exactly "count_next leaves >= 2 free slots".
      in_ready_r <= (count_nxt_s <= READY_MAX_C);
    end
  end

  // Entry storage; not reset, occupancy is tracked by count_r alone.
  always_ff @(posedge clk) begin
    if (!bus.flush && (push_n_s != ZERO_C)) begin
      mem_r[tail_r] <= bus.in_a;
      if (push_n_s == TWO_C) begin
        mem_r[tail_p1_s] <= bus.in_b;
      end
    end
  end

  // Slot presentation: empty slots are shown as bubbles (execute forced low).
  always_comb begin
    cur_a_s = mem_r[head_r];
    cur_b_s = mem_r[head_p1_s];
    if (count_r == ZERO_C) begin
      cur_a_s.ctrl.execute = 1'b0;
    end else begin
      cur_a_s.ctrl.execute = mem_r[head_r].ctrl.execute;
    end
    if (count_r < TWO_C) begin
      cur_b_s.ctrl.execute = 1'b0;
    end else begin
      cur_b_s.ctrl.execute = mem_r[head_p1_s].ctrl.execute;
    end
  end

  assign bus.cur_a    = cur_a_s;
  assign bus.cur_b    = cur_b_s;
  assign bus.count    = count_r;
  assign bus.in_ready = in_ready_r;

  core_dispatch_queue_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .dispatch_a (bus.dispatch_a),
    .dispatch_b (bus.dispatch_b),
    .count      (count_r)
  );

endmodule

// Simulation-time protocol and occupancy checks for the dispatch queue.
//   clk, rst_n       : as the queue
//   dispatch_a/b     : verdicts from dispatch
//   count            : registered occupancy
module core_dispatch_queue_chk #(
  parameter int DEPTH = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  input logic                       dispatch_a,
  input logic                       dispatch_b,
  input logic [$clog2(DEPTH):0]     count
);

  // Slot B may only be dispatched together with slot A.
  a_b_needs_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(dispatch_b && !dispatch_a));

  // Occupancy can never exceed the storage size.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (count <= ($clog2(DEPTH)+1)'(DEPTH)));

endmodule

// File: tb/tb_core_dispatch_queue.sv
// Directed self-checking bench for core_dispatch_queue (DEPTH = 8).
module tb_core_dispatch_queue;
  import core_dispatch_queue_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  core_dispatch_queue_if #(.DEPTH(8)) bus_if ();

  core_dispatch_queue #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, recognisable instruction for tag n.
  function automatic insn_decode mk(input int n);
    insn_decode r;
    r.pc           = 32'h0000_1000 + 32'(n) * 32'd4;
    r.imm          = 32'hA5A5_0000 ^ 32'(n);
    r.rs1          = 5'(n);
    r.rs2          = 5'(n + 7);
    r.ctrl.execute = 1'b1;
    r.ctrl.alu_op  = 4'(n);
    r.ctrl.rd      = 5'(n + 3);
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic va, input logic vb, input insn_decode a, input insn_decode b,
                       input logic da, input logic db, input logic fl);
    bus_if.in_valid_a = va;
    bus_if.in_valid_b = vb;
    bus_if.in_a       = a;
    bus_if.in_b       = b;
    bus_if.dispatch_a = da;
    bus_if.dispatch_b = db;
    bus_if.flush      = fl;
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, mk(0), mk(0), 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    check_eq("rst_ready", 128'(bus_if.in_ready), 128'(1'b1));
    check_eq("rst_count", 128'(bus_if.count), 128'(4'd0));
    check_eq("rst_exec_a", 128'(bus_if.cur_a.ctrl.execute), 128'(1'b0));
    check_eq("rst_exec_b", 128'(bus_if.cur_b.ctrl.execute), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Dispatch verdicts on an empty queue pop nothing
    drive(1'b0, 1'b0, mk(0), mk(0), 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("idle_count", 128'(bus_if.count), 128'(4'd0));
    check_eq("idle_exec_a", 128'(bus_if.cur_a.ctrl.execute), 128'(1'b0));

    // Two pushed pairs
    drive(1'b1, 1'b1, mk(0), mk(1), 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("p1_count", 128'(bus_if.count), 128'(4'd2));
    check_eq("p1_cur_a", 128'(bus_if.cur_a), 128'(mk(0)));
    check_eq("p1_cur_b", 128'(bus_if.cur_b), 128'(mk(1)));
    drive(1'b1, 1'b1, mk(2), mk(3), 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("p2_count", 128'(bus_if.count), 128'(4'd4));

    // Single then double retire
    drive(1'b0, 1'b0, mk(0), mk(0), 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("d1_cur_a", 128'(bus_if.cur_a), 128'(mk(1)));
    check_eq("d1_cur_b", 128'(bus_if.cur_b), 128'(mk(2)));
    check_eq("d1_count", 128'(bus_if.count), 128'(4'd3));
    drive(1'b0, 1'b0, mk(0), mk(0), 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("d2_cur_a", 128'(bus_if.cur_a), 128'(mk(3)));
    check_eq("d2_exec_b", 128'(bus_if.cur_b.ctrl.execute), 128'(1'b0));
    check_eq("d2_count", 128'(bus_if.count), 128'(4'd1));

    // Fill towards full: I3 | I4 I5 | I6 I7 | I8 -> 6 entries
    drive(1'b1, 1'b1, mk(4), mk(5), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, mk(6), mk(7), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, mk(8), mk(99), 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("f6_count", 128'(bus_if.count), 128'(4'd6));
    check_eq("f6_ready", 128'(bus_if.in_ready), 128'(1'b1));
    drive(1'b1, 1'b1, mk(9), mk(10), 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("f8_count", 128'(bus_if.count), 128'(4'd8));
    check_eq("f8_ready", 128'(bus_if.in_ready), 128'(1'b0));

    // Push is refused while not ready; pop still happens
    drive(1'b1, 1'b1, mk(11), mk(12), 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("f7_count", 128'(bus_if.count), 128'(4'd7));
    check_eq("f7_ready", 128'(bus_if.in_ready), 128'(1'b0));
    check_eq("f7_cur_a", 128'(bus_if.cur_a), 128'(mk(4)));
    drive(1'b1, 1'b1, mk(11), mk(12), 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("f5_count", 128'(bus_if.count), 128'(4'd5));
    check_eq("f5_cur_a", 128'(bus_if.cur_a), 128'(mk(6)));
    check_eq("f5_cur_b", 128'(bus_if.cur_b), 128'(mk(7)));
    check_eq("f5_ready", 128'(bus_if.in_ready), 128'(1'b1));

    // Flush wins over a same-cycle push and pop
    drive(1'b1, 1'b1, mk(300), mk(301), 1'b1, 1'b0, 1'b1);
    tick();
    check_eq("fl_count", 128'(bus_if.count), 128'(4'd0));
    check_eq("fl_exec_a", 128'(bus_if.cur_a.ctrl.execute), 128'(1'b0));
    check_eq("fl_exec_b", 128'(bus_if.cur_b.ctrl.execute), 128'(1'b0));
    check_eq("fl_ready", 128'(bus_if.in_ready), 128'(1'b1));
    drive(1'b1, 1'b1, mk(200), mk(201), 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("j_cur_a", 128'(bus_if.cur_a), 128'(mk(200)));
    check_eq("j_cur_b", 128'(bus_if.cur_b), 128'(mk(201)));
    check_eq("j_count", 128'(bus_if.count), 128'(4'd2));

    // Simultaneous single push and single pop; leaves head odd for the wrap run
    drive(1'b1, 1'b0, mk(202), mk(99), 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("sp_count", 128'(bus_if.count), 128'(4'd2));
    check_eq("sp_cur_a", 128'(bus_if.cur_a), 128'(mk(201)));
    check_eq("sp_cur_b", 128'(bus_if.cur_b), 128'(mk(202)));
    drive(1'b0, 1'b0, mk(0), mk(0), 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("sp_drain", 128'(bus_if.count), 128'(4'd0));

    // Streaming through several pointer wraps (head passes through 7)
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, mk(100 + 2*k), mk(101 + 2*k), 1'b1, 1'b1, 1'b0);
      tick();
      check_eq($sformatf("wr%0d_count", k), 128'(bus_if.count), 128'(4'd2));
      check_eq($sformatf("wr%0d_cur_a", k), 128'(bus_if.cur_a), 128'(mk(100 + 2*k)));
      check_eq($sformatf("wr%0d_cur_b", k), 128'(bus_if.cur_b), 128'(mk(101 + 2*k)));
    end
    drive(1'b0, 1'b0, mk(0), mk(0), 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("wr_drain", 128'(bus_if.count), 128'(4'd0));

    // Asynchronous reset mid-operation drops entries immediately
    drive(1'b1, 1'b1, mk(400), mk(401), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, mk(0), mk(0), 1'b0, 1'b0, 1'b0);
    check_eq("mr_pre", 128'(bus_if.count), 128'(4'd2));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_count", 128'(bus_if.count), 128'(4'd0));
    check_eq("mr_exec_a", 128'(bus_if.cur_a.ctrl.execute), 128'(1'b0));
    check_eq("mr_ready", 128'(bus_if.in_ready), 128'(1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
